// File: rtl/eu_shifter_seq_pkg.sv
// Shared definitions for the sequential EU shifter: opcodes, FSM state encoding
// and the opcode legality helper.
package eu_pkg;

  localparam logic [3:0] OP_MOVB = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_SHL  = 4'b1110;
  localparam logic [3:0] OP_ASR  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Every shifter opcode lives in the 11xx quadrant of the EU opcode map.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/eu_shifter_seq_if.sv
// Request/response bundle between the sequencer (master) and the shifter (slave).
interface eu_shifter_seq_if #(
  parameter int BUS_WIDTH = 16
);
  localparam int SHAMT_W = $clog2(BUS_WIDTH);

  logic                 start;
  logic [3:0]           op_select;
  logic [BUS_WIDTH-1:0] B;
  logic [SHAMT_W-1:0]   shamt;
  logic                 busy;
  logic                 done;
  logic [BUS_WIDTH-1:0] data_out;
  logic                 carry_out;
  logic                 err;

  modport master (
    output start, op_select, B, shamt,
    input  busy, done, data_out, carry_out, err
  );

  modport slave (
    input  start, op_select, B, shamt,
    output busy, done, data_out, carry_out, err
  );

endinterface

// File: rtl/eu_shifter_seq_step.sv
// One shifting stage: moves the work word by k (1..STEP) bits and reports the
// last bit pushed out. k == 0 passes the word through untouched.
module eu_shift_step
  import eu_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int SHAMT_W   = $clog2(BUS_WIDTH)
) (
  input  logic [BUS_WIDTH-1:0] in,
  input  logic [SHAMT_W-1:0]   k,
  input  logic [3:0]           op,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 bit_out
);

  localparam logic [BUS_WIDTH-1:0] LSB_ONE = {{(BUS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BUS_WIDTH-1:0] MSB_ONE = {1'b1, {(BUS_WIDTH-1){1'b0}}};

  logic signed [BUS_WIDTH-1:0] in_signed_s;
  logic        [SHAMT_W-1:0]   km1_s;

  assign in_signed_s = in;
  assign km1_s       = k - {{(SHAMT_W-1){1'b0}}, 1'b1};

  // Last bit out is selected by a one-hot mask so no variable bit index is needed.
  always_comb begin
    out     = in;
    bit_out = 1'b0;
    if (k == {SHAMT_W{1'b0}}) begin
      out     = in;
      bit_out = 1'b0;
    end else begin
      case (op)
        OP_SHR: begin
          out     = in >> k;
          bit_out = |(in & (LSB_ONE << km1_s));
        end
        OP_ASR: begin
          out     = in_signed_s >>> k;
          bit_out = |(in & (LSB_ONE << km1_s));
        end
        OP_SHL: begin
          out     = in << k;
          bit_out = |(in & (MSB_ONE >> km1_s));
        end
        default: begin
          out     = in;
          bit_out = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/eu_shifter_seq.sv
// Multi-cycle EU shifter: MOVB/SHR/SHL/ASR of B by shamt, STEP bits per clock,
// with a start/busy/done handshake and carry-out / illegal-op reporting.
module eu_shifter_seq
  import eu_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int STEP      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  eu_shifter_seq_if.slave         bus
);

  localparam int SHAMT_W = $clog2(BUS_WIDTH);
  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

  state_t               state_r;
  logic [SHAMT_W-1:0]   cnt_r;
  logic [BUS_WIDTH-1:0] work_r;
  logic [3:0]           op_r;
  logic                 busy_r;
  logic                 done_r;
  logic [BUS_WIDTH-1:0] data_out_r;
  logic                 carry_out_r;
  logic                 err_r;

  logic [SHAMT_W-1:0]   k_s;
  logic [BUS_WIDTH-1:0] step_out_s;
  logic                 step_bit_s;

  assign k_s = (cnt_r > STEP_K) ? STEP_K : cnt_r;

  eu_shift_step #(
    .BUS_WIDTH (BUS_WIDTH),
    .SHAMT_W   (SHAMT_W)
  ) u_step (
    .in      (work_r),
    .k       (k_s),
    .op      (op_r),
    .out     (step_out_s),
    .bit_out (step_bit_s)
  );

  // Control FSM, work register, down-counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {SHAMT_W{1'b0}};
      work_r      <= {BUS_WIDTH{1'b0}};
      op_r        <= 4'b0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      data_out_r  <= {BUS_WIDTH{1'b0}};
      carry_out_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            err_r <= ~is_legal_op(bus.op_select);
            if (!is_legal_op(bus.op_select)) begin
              state_r     <= DONE;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              data_out_r  <= {BUS_WIDTH{1'b0}};
              carry_out_r <= 1'b0;
            end else if ((bus.op_select == OP_MOVB) || (bus.shamt == {SHAMT_W{1'b0}})) begin
              state_r     <= DONE;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              data_out_r  <= bus.B;
              carry_out_r <= 1'b0;
            end else begin
              state_r <= SHIFT;
              busy_r  <= 1'b1;
              work_r  <= bus.B;
              cnt_r   <= bus.shamt;
              op_r    <= bus.op_select;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        SHIFT: begin
          work_r <= step_out_s;
          cnt_r  <= cnt_r - k_s;
          // The stage that empties the counter also publishes the result.
          if (cnt_r == k_s) begin
            state_r     <= DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            data_out_r  <= step_out_s;
            carry_out_r <= step_bit_s;
          end else begin
            state_r <= SHIFT;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.data_out  = data_out_r;
  assign bus.carry_out = carry_out_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_eu_shifter_seq.sv
// Directed bench for eu_shifter_seq: one instance with STEP=1 and one with STEP=4.
module tb_eu_shifter_seq;
  import eu_pkg::*;

  logic clk;
  logic rst;
  logic sel;
  int   n_assert;
  int   n_fail;
  int   overlap;

  eu_shifter_seq_if #(.BUS_WIDTH(16)) if1 ();
  eu_shifter_seq_if #(.BUS_WIDTH(16)) if4 ();

  eu_shifter_seq #(.BUS_WIDTH(16), .STEP(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  eu_shifter_seq #(.BUS_WIDTH(16), .STEP(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  logic        done_s;
  logic        busy_s;
  logic [15:0] data_s;
  logic        carry_s;
  logic        err_s;

  assign done_s  = sel ? if4.done      : if1.done;
  assign busy_s  = sel ? if4.busy      : if1.busy;
  assign data_s  = sel ? if4.data_out  : if1.data_out;
  assign carry_s = sel ? if4.carry_out : if1.carry_out;
  assign err_s   = sel ? if4.err       : if1.err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] op, input logic [15:0] b, input logic [3:0] sh,
                        input logic st);
    if (sel) begin
      if4.op_select = op; if4.B = b; if4.shamt = sh; if4.start = st;
    end else begin
      if1.op_select = op; if1.B = b; if1.shamt = sh; if1.start = st;
    end
  endtask

  // Issue one request from a negedge; lat counts edges from the accept edge (=1) to done.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] b,
                       input logic [3:0] sh, input int lat, input logic [15:0] ed,
                       input logic ec, input logic ee);
    int n;
    set_in(op, b, sh, 1'b1);
    @(posedge clk); #1;
    set_in(op, b, sh, 1'b0);
    n = 1;
    while (!done_s && n < 40) begin
      if (busy_s && done_s) overlap++;
      @(posedge clk); #1;
      n++;
    end
    if (busy_s && done_s) overlap++;
    check({tag, " latency"}, n, lat);
    check({tag, " done"}, {31'd0, done_s}, 32'd1);
    check({tag, " data"}, {16'd0, data_s}, {16'd0, ed});
    check({tag, " carry"}, {31'd0, carry_s}, {31'd0, ec});
    check({tag, " err"}, {31'd0, err_s}, {31'd0, ee});
    @(negedge clk);
  endtask

  initial begin
    int n;
    int any_done;
    n_assert = 0; n_fail = 0; overlap = 0;
    sel = 1'b0;
    rst = 1'b1;
    if1.start = 1'b0; if1.op_select = 4'd0; if1.B = 16'd0; if1.shamt = 4'd0;
    if4.start = 1'b0; if4.op_select = 4'd0; if4.B = 16'd0; if4.shamt = 4'd0;
    #12 rst = 1'b0;
    @(negedge clk);

    check("reset done", {31'd0, if1.done}, 32'd0);
    check("reset busy", {31'd0, if1.busy}, 32'd0);
    check("reset data", {16'd0, if1.data_out}, 32'd0);
    check("reset err", {31'd0, if4.err}, 32'd0);

    // Reset in the middle of a SHL 0x00FF by 8.
    set_in(OP_SHL, 16'h00FF, 4'd8, 1'b1);
    @(posedge clk); #1;
    set_in(OP_SHL, 16'h00FF, 4'd8, 1'b0);
    check("shift busy", {31'd0, busy_s}, 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy_s}, 32'd0);
    check("abort done", {31'd0, done_s}, 32'd0);
    check("abort data", {16'd0, data_s}, 32'd0);
    check("abort carry", {31'd0, carry_s}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    any_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done_s) any_done++;
    end
    check("no done after abort", any_done, 0);
    @(negedge clk);
    do_op("movb face", OP_MOVB, 16'hFACE, 4'd0, 1, 16'hFACE, 1'b0, 1'b0);

    do_op("shr 1", OP_SHR, 16'h1001, 4'd1, 2, 16'h0800, 1'b1, 1'b0);
    do_op("shl 1", OP_SHL, 16'h8001, 4'd1, 2, 16'h0002, 1'b1, 1'b0);
    do_op("asr 3", OP_ASR, 16'h8000, 4'd3, 4, 16'hF000, 1'b0, 1'b0);
    do_op("asr 15", OP_ASR, 16'h7FFF, 4'd15, 16, 16'h0000, 1'b1, 1'b0);
    do_op("shl 0", OP_SHL, 16'h1234, 4'd0, 1, 16'h1234, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("data hold", {16'd0, data_s}, 32'h1234);
    @(negedge clk);

    sel = 1'b1;
    do_op("s4 shl 6", OP_SHL, 16'h1001, 4'd6, 3, 16'h0040, 1'b0, 1'b0);
    do_op("s4 shr 5", OP_SHR, 16'hF00F, 4'd5, 3, 16'h0780, 1'b0, 1'b0);
    do_op("s4 asr 4", OP_ASR, 16'h8008, 4'd4, 2, 16'hF800, 1'b1, 1'b0);
    sel = 1'b0;

    // start held high through SHIFT; the MOVB is only taken once DONE is reached.
    set_in(OP_SHR, 16'h00F0, 4'd4, 1'b1);
    @(posedge clk); #1;
    set_in(OP_MOVB, 16'hCAFE, 4'd0, 1'b1);
    n = 1;
    while (!done_s && n < 40) begin
      if (busy_s && done_s) overlap++;
      @(posedge clk); #1;
      n++;
    end
    check("hold latency", n, 5);
    check("hold data", {16'd0, data_s}, 32'h000F);
    check("hold carry", {31'd0, carry_s}, 32'd0);
    @(posedge clk); #1;
    set_in(OP_MOVB, 16'hCAFE, 4'd0, 1'b0);
    check("b2b done", {31'd0, done_s}, 32'd1);
    check("b2b data", {16'd0, data_s}, 32'hCAFE);
    check("b2b busy", {31'd0, busy_s}, 32'd0);
    @(posedge clk); #1;
    check("done pulse", {31'd0, done_s}, 32'd0);
    @(negedge clk);

    do_op("illegal", 4'b0011, 16'hFFFF, 4'd3, 1, 16'h0000, 1'b0, 1'b1);
    do_op("err clear", OP_SHR, 16'h1001, 4'd1, 2, 16'h0800, 1'b1, 1'b0);
    check("busy/done overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
